utxd_param_tx: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 single-byte transmitter. Frame format is set by parameters: data width, parity mode and stop-bit count. A small synchronous FIFO buffers words from the host. Queued words go out as back-to-back frames with no idle gap. Sits between the host/test logic and the board UTXD pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/utx_fifo.sv | 55 +++++
 rtl/utxd_param_tx.sv | 147 ++++++++++++++
 tb/tb_utxd_param_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and helper functions
package uart_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest data word any transmitter build supports
  localparam int NB_MAX = 9;

  // Width of the per-tact clock counter
  typedef logic [15:0] tact_cnt_t;

  // Tacts per frame: start + data + optional parity + stop bits
  function automatic int frame_len(input int nb, input int par, input int nstop);
    return 1 + nb + ((par != PAR_NONE) ? 1 : 0) + nstop;
  endfunction

  // Parity bit for a zero-padded data word; even = XOR of bits, odd = complement
  function automatic logic parity_bit(input logic [NB_MAX-1:0] d, input int par);
    return (^d) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/utx_fifo.sv
// rtl/utx_fifo.sv - synchronous word FIFO with combinational head output
module utx_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr;
  logic          do_rd;

  // full/empty come from the pre-edge count, so a write while full is dropped
  // even when a pop happens in the same cycle
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign dout  = mem_q[rp_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + AW'(1);
      if (do_rd) rp_q <= rp_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/utxd_param_tx.sv
// rtl/utxd_param_tx.sv - parametrised UART transmitter with input FIFO
module utxd_param_tx
  import uart_pkg::*;
#(
  parameter int Fclk  = 50000000,
  parameter int VEL   = 57600,
  parameter int NB    = 8,
  parameter int PAR   = 0,
  parameter int NSTOP = 1,
  parameter int AW    = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NB-1:0]                                  dat,
  input  logic                                           wr,
  output logic                                           full,
  output logic                                           empty,
  output logic                                           ovf,
  output logic                                           UTXD,
  output logic                                           en_tx_byte,
  output logic                                           ce_tact,
  output logic [$clog2(frame_len(NB, PAR, NSTOP))-1:0]   cb_bit,
  output logic                                           T_start,
  output logic                                           T_dat,
  output logic                                           T_par,
  output logic                                           T_stop,
  output logic                                           ce_stop
);

  localparam int NF  = frame_len(NB, PAR, NSTOP);
  localparam int CBW = $clog2(NF);
  localparam int NT  = Fclk / VEL;
  localparam int NPB = (PAR != PAR_NONE) ? 1 : 0;

  localparam tact_cnt_t      NT_C         = 16'(NT);
  localparam logic [CBW-1:0] BIT_DAT_LAST = CBW'(NB);
  localparam logic [CBW-1:0] BIT_PAR      = CBW'(NB + 1);
  localparam logic [CBW-1:0] BIT_STOP0    = CBW'(NB + 1 + NPB);
  localparam logic [CBW-1:0] BIT_LAST     = CBW'(NF - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [0:0]     state_q, state_d;
  tact_cnt_t      tact_q,  tact_d;
  logic [CBW-1:0] bit_q,   bit_d;
  logic [NB-1:0]  sr_q,    sr_d;
  logic           par_q,   par_d;
  logic           utxd_q,  utxd_d;
  logic           ovf_q,   ovf_d;

  logic [NB-1:0]  fifo_dout;
  logic           pop;

  utx_fifo #(
    .W  (NB),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .din   (dat),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // cb_tact idles at 0, so ce_tact can only fire inside a frame
  assign en_tx_byte = (state_q == ST_FRAME);
  assign ce_tact    = (tact_q == NT_C);
  assign ce_stop    = ce_tact & en_tx_byte & (bit_q == BIT_LAST);
  assign cb_bit     = bit_q;

  // A new frame starts from idle or straight out of the last stop tact
  assign pop = ~empty & (~en_tx_byte | ce_stop);

  assign T_start = en_tx_byte & (bit_q == '0);
  assign T_dat   = en_tx_byte & (bit_q != '0) & (bit_q <= BIT_DAT_LAST);
  assign T_par   = en_tx_byte & (NPB != 0) & (bit_q == BIT_PAR);
  assign T_stop  = en_tx_byte & (bit_q >= BIT_STOP0);

  assign ovf_d = wr & full;
  assign UTXD  = utxd_q;
  assign ovf   = ovf_q;

  // Frame sequencing: load, tact counting, bit stepping and data shifting
  always_comb begin
    state_d = state_q;
    tact_d  = tact_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    par_d   = par_q;
    if (pop) begin
      state_d = ST_FRAME;
      tact_d  = 16'd1;
      bit_d   = '0;
      sr_d    = fifo_dout;
      par_d   = parity_bit(NB_MAX'(fifo_dout), PAR);
    end else if (ce_stop) begin
      state_d = ST_IDLE;
      tact_d  = '0;
      bit_d   = '0;
    end else if (en_tx_byte) begin
      if (ce_tact) begin
        tact_d = 16'd1;
        bit_d  = bit_q + CBW'(1);
        if (T_dat) sr_d = sr_q >> 1;
      end else begin
        tact_d = tact_q + 16'd1;
      end
    end
  end

  // Line level derived from next state so the pin itself is a flop output
  always_comb begin
    utxd_d = 1'b1;
    if (state_d == ST_FRAME) begin
      if (bit_d == '0)                             utxd_d = 1'b0;
      else if (bit_d <= BIT_DAT_LAST)              utxd_d = sr_d[0];
      else if ((NPB != 0) && (bit_d == BIT_PAR))   utxd_d = par_d;
      else                                         utxd_d = 1'b1;
    end
  end

  // State registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tact_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      utxd_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tact_q  <= tact_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      utxd_q  <= utxd_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_utxd_param_tx.sv
// tb/tb_utxd_param_tx.sv - directed self-checking bench for utxd_param_tx
module tb_utxd_param_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] dat_r [4];
  logic       wr_r [4];
  logic       full_w [4], empty_w [4], ovf_w [4], utxd_w [4], en_w [4];
  logic       ce_tact_w [4], t_start_w [4], t_dat_w [4], t_par_w [4], t_stop_w [4], ce_stop_w [4];
  logic [3:0] cb_bit_w [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7O2; all Nt = 16, depth 4
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int GNB   = (g == 3) ? 7 : 8;
    localparam int GPAR  = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
    localparam int GSTOP = (g == 3) ? 2 : 1;
    utxd_param_tx #(
      .Fclk(1600), .VEL(100), .NB(GNB), .PAR(GPAR), .NSTOP(GSTOP), .AW(2)
    ) u_dut (
      .clk(clk), .rst(rst), .dat(dat_r[g][GNB-1:0]), .wr(wr_r[g]),
      .full(full_w[g]), .empty(empty_w[g]), .ovf(ovf_w[g]), .UTXD(utxd_w[g]),
      .en_tx_byte(en_w[g]), .ce_tact(ce_tact_w[g]), .cb_bit(cb_bit_w[g]),
      .T_start(t_start_w[g]), .T_dat(t_dat_w[g]), .T_par(t_par_w[g]),
      .T_stop(t_stop_w[g]), .ce_stop(ce_stop_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walks a frame from clock j0 (1 = first clock after the load edge) to its
  // ce_stop clock; bits[t] is the expected line level in tact t
  task automatic frame_check(input int s, input logic [15:0] bits, input int nf,
                             input int nb, input int np, input int j0, input string tag);
    for (int j = j0; j <= nf * 16; j++) begin
      int t;
      t = (j - 1) / 16;
      check($sformatf("%s utxd j%0d", tag, j), 32'(utxd_w[s]), 32'(bits[t]));
      check($sformatf("%s ce_stop j%0d", tag, j), 32'(ce_stop_w[s]), 32'(j == nf * 16));
      check($sformatf("%s ce_tact j%0d", tag, j), 32'(ce_tact_w[s]), 32'((j % 16) == 0));
      if ((j - 1) % 16 == 0) begin
        check($sformatf("%s en t%0d", tag, t), 32'(en_w[s]), 32'(1));
        check($sformatf("%s cb_bit t%0d", tag, t), 32'(cb_bit_w[s]), 32'(t));
        check($sformatf("%s T_start t%0d", tag, t), 32'(t_start_w[s]), 32'(t == 0));
        check($sformatf("%s T_dat t%0d", tag, t), 32'(t_dat_w[s]), 32'(t >= 1 && t <= nb));
        check($sformatf("%s T_par t%0d", tag, t), 32'(t_par_w[s]), 32'(np != 0 && t == nb + 1));
        check($sformatf("%s T_stop t%0d", tag, t), 32'(t_stop_w[s]), 32'(t >= nb + 1 + np));
      end
      if (j != nf * 16) @(negedge clk);
    end
  endtask

  // Single word into an idle, empty instance: visible at edge k, loads at k+1
  task automatic tx_one(input int s, input logic [7:0] d, input logic [15:0] bits,
                        input int nf, input int nb, input int np, input string tag);
    wr_r[s] = 1'b1; dat_r[s] = d;
    @(negedge clk);
    wr_r[s] = 1'b0;
    check({tag, " queued empty"}, 32'(empty_w[s]), 32'(0));
    check({tag, " queued en"}, 32'(en_w[s]), 32'(0));
    check({tag, " queued utxd"}, 32'(utxd_w[s]), 32'(1));
    @(negedge clk);
    frame_check(s, bits, nf, nb, np, 1, tag);
    @(negedge clk);
    check({tag, " after en"}, 32'(en_w[s]), 32'(0));
    check({tag, " after utxd"}, 32'(utxd_w[s]), 32'(1));
    check({tag, " after empty"}, 32'(empty_w[s]), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_r[k]  = 1'b0;
      dat_r[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst utxd %0d", k), 32'(utxd_w[k]), 32'(1));
      check($sformatf("rst en %0d", k), 32'(en_w[k]), 32'(0));
      check($sformatf("rst empty %0d", k), 32'(empty_w[k]), 32'(1));
      check($sformatf("rst full %0d", k), 32'(full_w[k]), 32'(0));
      check($sformatf("rst ovf %0d", k), 32'(ovf_w[k]), 32'(0));
      check($sformatf("rst cb_bit %0d", k), 32'(cb_bit_w[k]), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    tx_one(0, 8'hA5, 16'h034A, 10, 8, 0, "t1");
    // 8E1 0xA5: parity 0; 8O1 0xA5: parity 1
    tx_one(1, 8'hA5, 16'h054A, 11, 8, 1, "t2e");
    tx_one(2, 8'hA5, 16'h074A, 11, 8, 1, "t2o");
    // 7O2 0x41: data 1,0,0,0,0,0,1, parity 1, two stops
    tx_one(3, 8'h41, 16'h0782, 11, 7, 1, "t3");

    // Burst of five writes, then an overflow write
    wr_r[0] = 1'b1; dat_r[0] = 8'h01;
    @(negedge clk);
    check("t4 e0 empty", 32'(empty_w[0]), 32'(0));
    dat_r[0] = 8'h02;
    @(negedge clk);
    check("t4 j1 en", 32'(en_w[0]), 32'(1));
    check("t4 j1 utxd", 32'(utxd_w[0]), 32'(0));
    dat_r[0] = 8'h03;
    @(negedge clk);
    dat_r[0] = 8'h04;
    @(negedge clk);
    dat_r[0] = 8'h05;
    @(negedge clk);
    check("t4 j4 full", 32'(full_w[0]), 32'(1));
    check("t4 j4 ovf", 32'(ovf_w[0]), 32'(0));
    dat_r[0] = 8'h06;
    @(negedge clk);
    wr_r[0] = 1'b0;
    check("t4 j5 ovf", 32'(ovf_w[0]), 32'(1));
    check("t4 j5 full", 32'(full_w[0]), 32'(1));
    @(negedge clk);
    check("t4 j6 ovf", 32'(ovf_w[0]), 32'(0));
    frame_check(0, 16'h0202, 10, 8, 0, 6, "t4 f1");
    for (int f = 2; f <= 5; f++) begin
      @(negedge clk);
      check($sformatf("t4 f%0d empty", f), 32'(empty_w[0]), 32'(f == 5));
      frame_check(0, 16'h0200 | 16'(f << 1), 10, 8, 0, 1, $sformatf("t4 f%0d", f));
    end
    @(negedge clk);
    check("t4 end en", 32'(en_w[0]), 32'(0));
    check("t4 end utxd", 32'(utxd_w[0]), 32'(1));
    check("t4 end empty", 32'(empty_w[0]), 32'(1));

    // Write lands on the ce_stop edge of a frame with an empty FIFO
    wr_r[0] = 1'b1; dat_r[0] = 8'hC3;
    @(negedge clk);
    wr_r[0] = 1'b0;
    @(negedge clk);
    frame_check(0, 16'h0386, 10, 8, 0, 1, "t5 f1");
    wr_r[0] = 1'b1; dat_r[0] = 8'h3C;
    @(negedge clk);
    wr_r[0] = 1'b0;
    check("t5 gap en", 32'(en_w[0]), 32'(0));
    check("t5 gap utxd", 32'(utxd_w[0]), 32'(1));
    check("t5 gap empty", 32'(empty_w[0]), 32'(0));
    @(negedge clk);
    frame_check(0, 16'h0278, 10, 8, 0, 1, "t5 f2");
    @(negedge clk);
    check("t5 end en", 32'(en_w[0]), 32'(0));
    check("t5 end empty", 32'(empty_w[0]), 32'(1));

    // Reset at clock 50 of a frame with two words queued
    wr_r[0] = 1'b1; dat_r[0] = 8'h11;
    @(negedge clk);
    dat_r[0] = 8'h22;
    @(negedge clk);
    dat_r[0] = 8'h33;
    @(negedge clk);
    wr_r[0] = 1'b0;
    check("t6 j2 empty", 32'(empty_w[0]), 32'(0));
    check("t6 j2 utxd", 32'(utxd_w[0]), 32'(0));
    repeat (47) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 rst utxd", 32'(utxd_w[0]), 32'(1));
    check("t6 rst en", 32'(en_w[0]), 32'(0));
    check("t6 rst empty", 32'(empty_w[0]), 32'(1));
    check("t6 rst full", 32'(full_w[0]), 32'(0));
    check("t6 rst cb_bit", 32'(cb_bit_w[0]), 32'(0));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check($sformatf("t6 quiet utxd %0d", i), 32'(utxd_w[0]), 32'(1));
      if (i % 10 == 0) check($sformatf("t6 quiet en %0d", i), 32'(en_w[0]), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
